// File: rtl/text_write_scheduler.sv
// Queues host char+attr cell writes and releases them to the glyph RAM only inside the video window; optional clear sweep under TEXT_CLEAR_EN.
// Latency: accept at edge n -> ram_we high after edge n+1; backpressure: host_ready = !full, independent of pops.
// Stalls with win_q=0; a write already popped in-window still lands one cycle past the window edge.

module fifo #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_vld,
   input  logic [DW-1:0] wr_dat,
   output logic          full,
   input  logic          rd_en,
   output logic [DW-1:0] rd_dat,
   output logic          empty,
   output logic [AW:0]   level
);
   localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

   logic [DW-1:0] mem [2**AW];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          wr_go;
   logic          rd_go;

   assign full   = (level == DEPTH);
   assign empty  = (level == '0);
   assign wr_go  = wr_vld && !full;
   assign rd_go  = rd_en && !empty;
   assign rd_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_go) mem[wr_ptr] <= wr_dat;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_go) wr_ptr <= wr_ptr + 1'b1;
         if (rd_go) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_go, rd_go})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end
endmodule

module text_write_scheduler #(
   parameter int                ADDR_W     = 12,
   parameter int                DATA_W     = 16,
   parameter int                CELLS      = 2720,
   parameter int                FIFO_AW    = 4,
   parameter int                WINDOW     = 0,
   parameter bit                SYNC_POL   = 1'b1,
   parameter logic [DATA_W-1:0] CLEAR_DATA = 16'h0720
) (
   input  logic              clk_pixel,
   input  logic              rst,
   input  logic              host_valid,
   output logic              host_ready,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_data,
   input  logic              vga_blank,
   input  logic              vga_vsync,
   input  logic              clear_req,
   output logic              clear_busy,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic [FIFO_AW:0]  fifo_level
);
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } cell_t;

`ifdef TEXT_CLEAR_EN
   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
`else
   typedef enum logic {IDLE = 1'b0} state_t;
`endif

   localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

   state_t state;
   state_t state_nxt;
   logic   win;
   logic   win_q;
   logic   full;
   logic   empty;
   logic   pop;
   logic   clr_wr;
   cell_t  wr_cell;
   cell_t  rd_cell;

   // Window is registered so every issue decision sees one stable sample per cycle.
   assign win        = (WINDOW == 0) ? vga_blank : (vga_vsync == SYNC_POL);
   assign host_ready = !full;
   assign wr_cell    = '{addr: host_addr, data: host_data};

   fifo #(
      .DW($bits(cell_t)),
      .AW(FIFO_AW)
   ) u_fifo (
      .clk    (clk_pixel),
      .rst    (rst),
      .wr_vld (host_valid),
      .wr_dat (wr_cell),
      .full   (full),
      .rd_en  (pop),
      .rd_dat (rd_cell),
      .empty  (empty),
      .level  (fifo_level)
   );

`ifdef TEXT_CLEAR_EN
   logic [ADDR_W-1:0] clr_cnt;
   assign clear_busy = (state == CLEAR);
`else
   logic unused_cfg;
   assign clear_busy = 1'b0;
   assign unused_cfg = ^{clear_req, CLEAR_DATA, LAST_CELL};
`endif

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      clr_wr    = 1'b0;
      case (state)
         IDLE: begin
`ifdef TEXT_CLEAR_EN
            // Clear takes priority over anything pending in the queue.
            if (clear_req) state_nxt = CLEAR;
            else if (win_q && !empty) pop = 1'b1;
`else
            if (win_q && !empty) pop = 1'b1;
`endif
         end
`ifdef TEXT_CLEAR_EN
         CLEAR: begin
            if (win_q) begin
               clr_wr = 1'b1;
               if (clr_cnt == LAST_CELL) state_nxt = IDLE;
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_pixel or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         win_q     <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
`ifdef TEXT_CLEAR_EN
         clr_cnt   <= '0;
`endif
      end else begin
         state  <= state_nxt;
         win_q  <= win;
         ram_we <= pop | clr_wr;
         if (pop) begin
            ram_addr  <= rd_cell.addr;
            ram_wdata <= rd_cell.data;
         end
`ifdef TEXT_CLEAR_EN
         else if (clr_wr) begin
            ram_addr  <= clr_cnt;
            ram_wdata <= CLEAR_DATA;
         end
         if (state == IDLE) clr_cnt <= '0;
         else if (clr_wr)   clr_cnt <= clr_cnt + 1'b1;
`endif
      end
   end
endmodule

// File: tb/tb_text_write_scheduler.sv
// Directed bench for text_write_scheduler: burst/drain, window close, latency, WINDOW=1 variant, clear sweep (TEXT_CLEAR_EN).
module tb_text_write_scheduler;
   logic        clk_pixel = 1'b0;
   logic        rst = 1'b1;
   logic        host_valid = 1'b0;
   logic        host_valid1 = 1'b0;
   logic [11:0] host_addr = '0;
   logic [15:0] host_data = '0;
   logic        vga_blank = 1'b0;
   logic        vga_vsync = 1'b0;
   logic        clear_req = 1'b0;
   logic        clear_req1 = 1'b0;

   logic        host_ready, clear_busy, ram_we;
   logic [11:0] ram_addr;
   logic [15:0] ram_wdata;
   logic [4:0]  fifo_level;
   logic        host_ready1, clear_busy1, ram_we1;
   logic [11:0] ram_addr1;
   logic [15:0] ram_wdata1;
   logic [4:0]  fifo_level1;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   logic [28:0] wq[$];
   int          wcyc[$];
   logic [27:0] w1q[$];
   logic [27:0] exp_q[$];
   logic [27:0] exp1_q[$];

   always #5 clk_pixel = ~clk_pixel;

   text_write_scheduler dut (
      .clk_pixel(clk_pixel), .rst(rst), .host_valid(host_valid), .host_ready(host_ready),
      .host_addr(host_addr), .host_data(host_data), .vga_blank(vga_blank), .vga_vsync(vga_vsync),
      .clear_req(clear_req), .clear_busy(clear_busy), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .fifo_level(fifo_level)
   );

   text_write_scheduler #(.WINDOW(1), .SYNC_POL(1'b1)) dut1 (
      .clk_pixel(clk_pixel), .rst(rst), .host_valid(host_valid1), .host_ready(host_ready1),
      .host_addr(host_addr), .host_data(host_data), .vga_blank(vga_blank), .vga_vsync(vga_vsync),
      .clear_req(clear_req1), .clear_busy(clear_busy1), .ram_we(ram_we1), .ram_addr(ram_addr1),
      .ram_wdata(ram_wdata1), .fifo_level(fifo_level1)
   );

   always @(posedge clk_pixel) begin
      #2;
      cyc++;
      if (ram_we) begin
         wq.push_back({clear_busy, ram_addr, ram_wdata});
         wcyc.push_back(cyc);
      end
      if (ram_we1) w1q.push_back({ram_addr1, ram_wdata1});
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [11:0] a, input logic [15:0] d);
      host_addr = a; host_data = d; host_valid = 1'b1;
      exp_q.push_back({a, d});
      @(negedge clk_pixel);
      host_valid = 1'b0;
   endtask

   task automatic push1(input logic [11:0] a, input logic [15:0] d);
      host_addr = a; host_data = d; host_valid1 = 1'b1;
      exp1_q.push_back({a, d});
      @(negedge clk_pixel);
      host_valid1 = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; host_valid = 1'b0; host_valid1 = 1'b0; clear_req = 1'b0;
      vga_blank = 1'b0; vga_vsync = 1'b0;
      repeat (2) @(negedge clk_pixel);
      rst = 1'b0;
      @(negedge clk_pixel);
      wq.delete(); wcyc.delete(); w1q.delete(); exp_q.delete(); exp1_q.delete();
   endtask

   // Mismatches between recorded writes starting at off and the expected host list.
   function automatic int cmp_seq(input int off);
      int bad = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (off + i >= wq.size()) bad++;
         else if (wq[off+i][27:0] !== exp_q[i]) bad++;
      end
      return bad;
   endfunction

   initial begin
      #1;
      check("rst_we", ram_we, 0);
      check("rst_addr", ram_addr, 0);
      check("rst_wdata", ram_wdata, 0);
      check("rst_level", fifo_level, 0);
      check("rst_busy", clear_busy, 0);
      do_reset();
      check("ready_after_rst", host_ready, 1);

      // Burst of 16 in active video, then one attempted overflow push.
      for (int i = 0; i < 16; i++) push(12'(i * 5 + 1), 16'(16'h4100 + i));
      check("burst_level", fifo_level, 16);
      check("burst_ready", host_ready, 0);
      host_addr = 12'hFFF; host_data = 16'hDEAD; host_valid = 1'b1;
      @(negedge clk_pixel);
      host_valid = 1'b0;
      check("full_level", fifo_level, 16);
      check("burst_no_we", wq.size(), 0);

      // Blank opens: drain 16 in order on consecutive cycles.
      vga_blank = 1'b1;
      @(negedge clk_pixel);
      check("open_level0", fifo_level, 16);
      @(negedge clk_pixel);
      check("open_level1", fifo_level, 15);
      check("open_ready", host_ready, 1);
      repeat (20) @(negedge clk_pixel);
      check("drain_cnt", wq.size(), 16);
      check("drain_order", cmp_seq(0), 0);
      check("drain_level", fifo_level, 0);
      if (wcyc.size() == 16) check("drain_back2back", wcyc[15] - wcyc[0], 15);
      else check("drain_back2back", wcyc.size(), 16);
      vga_blank = 1'b0;
      @(negedge clk_pixel);
      wq.delete(); wcyc.delete(); exp_q.delete();

      // Window closes mid-drain; entries 3/4 share an address.
      for (int i = 0; i < 10; i++) push((i == 4) ? 12'd33 : 12'(30 + i), 16'(16'hA500 + i));
      vga_blank = 1'b1;
      repeat (5) @(negedge clk_pixel);
      vga_blank = 1'b0;
      repeat (5) @(negedge clk_pixel);
      check("close_cnt", wq.size(), 5);
      check("close_level", fifo_level, 5);
      vga_blank = 1'b1;
      repeat (10) @(negedge clk_pixel);
      vga_blank = 1'b0;
      repeat (3) @(negedge clk_pixel);
      check("reopen_cnt", wq.size(), 10);
      check("reopen_order", cmp_seq(0), 0);
      check("reopen_level", fifo_level, 0);
      wq.delete(); wcyc.delete(); exp_q.delete();

      // Latency with window open, then streaming push+pop.
      vga_blank = 1'b1;
      repeat (2) @(negedge clk_pixel);
      push(12'h123, 16'h0F41);
      check("lat_we_n1", ram_we, 0);
      check("lat_level_n1", fifo_level, 1);
      @(negedge clk_pixel);
      check("lat_we_n2", ram_we, 1);
      check("lat_addr", ram_addr, 12'h123);
      check("lat_data", ram_wdata, 16'h0F41);
      check("lat_level_n2", fifo_level, 0);
      for (int i = 0; i < 6; i++) begin
         push(12'(200 + i), 16'(16'h1E00 + i));
         if (i == 2) check("pushpop_level", fifo_level, 1);
      end
      repeat (4) @(negedge clk_pixel);
      check("stream_cnt", wq.size(), 7);
      check("stream_order", cmp_seq(0), 0);
      check("stream_we_idle", ram_we, 0);
      check("hold_addr", ram_addr, 12'd205);
      vga_blank = 1'b0;

      // WINDOW=1 instance: blank alone must not release writes.
      do_reset();
      for (int i = 0; i < 3; i++) push1(12'(700 + i), 16'(16'h5A00 + i));
      vga_blank = 1'b1;
      repeat (5) @(negedge clk_pixel);
      vga_blank = 1'b0;
      repeat (3) @(negedge clk_pixel);
      check("w1_blank_cnt", w1q.size(), 0);
      check("w1_blank_level", fifo_level1, 3);
      vga_vsync = 1'b1;
      repeat (6) @(negedge clk_pixel);
      vga_vsync = 1'b0;
      repeat (3) @(negedge clk_pixel);
      check("w1_vs_cnt", w1q.size(), 3);
      for (int i = 0; i < 3; i++)
         if (i < w1q.size()) check("w1_vs_entry", w1q[i], exp1_q[i]);
      check("w1_vs_level", fifo_level1, 0);

`ifdef TEXT_CLEAR_EN
      begin
         int bad;
         do_reset();
         for (int i = 0; i < 3; i++) push(12'(10 + i), 16'(16'hC300 + i));
         vga_blank = 1'b1; clear_req = 1'b1;
         @(negedge clk_pixel);
         clear_req = 1'b0;
         check("clr_busy_on", clear_busy, 1);
         repeat (50) @(negedge clk_pixel);
         clear_req = 1'b1;
         @(negedge clk_pixel);
         clear_req = 1'b0;
         repeat (2700) @(negedge clk_pixel);
         check("clr_cnt", wq.size(), 2723);
         bad = 0;
         for (int i = 0; i < 2720; i++)
            if (i >= wq.size() || wq[i][27:0] !== {12'(i), 16'h0720}) bad++;
         check("clr_seq", bad, 0);
         if (wq.size() >= 2720) begin
            check("clr_busy_2718", wq[2718][28], 1);
            check("clr_busy_2719", wq[2719][28], 0);
         end
         check("clr_then_host", cmp_seq(2720), 0);
         check("clr_level", fifo_level, 0);
         check("clr_busy_off", clear_busy, 0);

         do_reset();
         for (int i = 0; i < 3; i++) push(12'(10 + i), 16'(16'hC300 + i));
         vga_blank = 1'b1; clear_req = 1'b1;
         @(negedge clk_pixel);
         clear_req = 1'b0;
         repeat (100) @(negedge clk_pixel);
         check("mid_clr_cnt", wq.size(), 100);
         check("mid_clr_we", ram_we, 1);
         rst = 1'b1;
         #1;
         check("mid_rst_we", ram_we, 0);
         check("mid_rst_busy", clear_busy, 0);
         check("mid_rst_level", fifo_level, 0);
         @(negedge clk_pixel);
         rst = 1'b0;
         wq.delete();
         repeat (10) @(negedge clk_pixel);
         check("post_rst_quiet", wq.size(), 0);
         vga_blank = 1'b0;
      end
`else
      do_reset();
      vga_blank = 1'b1; clear_req = 1'b1;
      @(negedge clk_pixel);
      clear_req = 1'b0;
      check("noclr_busy", clear_busy, 0);
      repeat (10) @(negedge clk_pixel);
      check("noclr_quiet", wq.size(), 0);
      vga_blank = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
